avalon_pio_poller: RTL and testbench
====================================

AVALON_PIO_POLLER -- requirements
Module: avalon_pio_poller

Interface
REQ-001 Parameter: DATA_W, default 32, width of the read data bus and of the captured value.
REQ-002 Parameter: ADDR_W, default 2, width of the master address bus.
REQ-003 Parameter: READ_LATENCY, default 1, fixed number of cycles from an accepted read to valid readdata (legal range 1..7).
REQ-004 Parameter: POLL_PERIOD, default 1000, number of cycles between automatic reads (legal range 2..65535).
REQ-005 Port: clk  in  1  single clock for all logic.
REQ-006 Port: reset  in  1  synchronous, active-high reset.
REQ-007 Port: enable  in  1  enables periodic polling.
REQ-008 Port: poll_now  in  1  single-cycle request for an immediate read.
REQ-009 Port: cfg_address  in  ADDR_W  target word address, sampled when a read is launched.
REQ-010 Port: address  out  ADDR_W  Avalon-MM master address.
REQ-011 Port: read  out  1  Avalon-MM master read strobe.
REQ-012 Port: waitrequest  in  1  slave stall; tie to 0 for slaves with no stall.
REQ-013 Port: readdata  in  DATA_W  slave read data.
REQ-014 Port: value  out  DATA_W  last captured readdata.
REQ-015 Port: value_valid  out  1  one-cycle pulse when value updates.
REQ-016 Port: changed  out  1  one-cycle pulse, coincident with value_valid, when the new value differs from the previous one.
REQ-017 Port: sample_count  out  16  number of completed reads.
REQ-018 Port: busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have four states: IDLE, REQ, WAIT, CAPTURE.
REQ-020 IDLE->REQ on launch: address latches cfg_address, and read SHALL be 1 in the following cycle.
REQ-021 REQ: read and address SHALL be held stable while waitrequest=1; the read is accepted on the first cycle with read=1 and waitrequest=0.
REQ-022 On acceptance, read SHALL drop the next cycle, and the FSM SHALL move to WAIT with a latency counter loaded.
REQ-023 readdata SHALL be sampled exactly READ_LATENCY cycles after the acceptance edge (CAPTURE entry); WAIT lasts READ_LATENCY-1 cycles, 0 when READ_LATENCY=1.
REQ-024 CAPTURE: value<=readdata; value_valid=1 for one cycle; sample_count increments, wrapping 65535->0; FSM->IDLE.
REQ-025 changed SHALL be 1 if the captured data differs from the prior value, or if this is the first capture after reset.
REQ-026 Poll timer: down-counter loaded with POLL_PERIOD-1; decrements each cycle while enable=1; on reaching 0, raises a launch request and reloads.
REQ-027 While enable=0, the timer SHALL hold its value; on the rising edge of enable, the timer SHALL reload.
REQ-028 poll_now while IDLE SHALL launch in the same cycle as a timer launch would; poll_now while busy SHALL set a single pending flag (further requests coalesce).
REQ-029 The pending flag or a timer expiry arriving while busy SHALL launch on the cycle the FSM returns to IDLE; the FSM SHALL spend at least one cycle in IDLE between reads.
REQ-030 A simultaneous timer expiry and poll_now SHALL produce exactly one read.
REQ-031 Deasserting enable mid-transaction SHALL NOT abort the transaction; it completes normally.
REQ-032 address SHALL change only on launch; value SHALL change only in CAPTURE.

Reset
REQ-033 With reset=1 at a clk edge: FSM=IDLE; read=0; address=0; value=0; value_valid=0; changed=0; sample_count=0; busy=0; pending cleared; timer=POLL_PERIOD-1; first-capture flag set.
REQ-034 Reset mid-transaction SHALL abort it: read=0 from the cycle after reset is sampled, and no value_valid for the aborted read.

Verification
REQ-035 Defaults, waitrequest=0, readdata=32'h0000_00A5, poll_now pulse -> read high 1 cycle, value=32'hA5 with value_valid=1 and changed=1 two cycles after the pulse, sample_count=1.
REQ-036 enable=1 with POLL_PERIOD=10 and constant readdata -> read every 10+ cycles; second and later captures give changed=0; sample_count increments each time.
REQ-037 waitrequest held high for 3 cycles during REQ -> read and address stable for 4 cycles; capture occurs READ_LATENCY cycles after the first waitrequest=0 cycle.
REQ-038 READ_LATENCY=3, and poll_now pulsed twice while busy -> exactly one extra read follows the first, with data sampled 3 cycles after acceptance.
REQ-039 Reset asserted during WAIT -> no value_valid, all outputs at their reset values; sample_count starting at 16'hFFFF -> 0 after one capture (wrap).

Source files
------------

// File: rtl/avalon_pio_poller.sv
// rtl/avalon_pio_poller.sv - periodic / on-demand Avalon-MM single-word read poller
module avalon_pio_poller #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 2,
  parameter int READ_LATENCY = 1,
  parameter int POLL_PERIOD  = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              poll_now,
  input  logic [ADDR_W-1:0] cfg_address,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  output logic [DATA_W-1:0] value,
  output logic              value_valid,
  output logic              changed,
  output logic [15:0]       sample_count,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPTURE} state_t;

  localparam logic [15:0] TIMER_RELOAD = 16'(POLL_PERIOD - 1);
  // WAIT spans READ_LATENCY-1 cycles, so the counter runs from READ_LATENCY-2 down to 0
  localparam logic [2:0]  WAIT_LOAD    = 3'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

  state_t      state;
  logic [2:0]  lat_cnt;
  logic [15:0] timer;
  logic        enable_d;
  logic        pending;
  logic        first_capture;
  logic        timer_fire;
  logic        launch_req;

  assign timer_fire = enable && enable_d && (timer == 16'd0);
  assign launch_req = poll_now || timer_fire || pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lat_cnt       <= 3'd0;
      timer         <= TIMER_RELOAD;
      enable_d      <= 1'b0;
      pending       <= 1'b0;
      first_capture <= 1'b1;
      address       <= '0;
      read          <= 1'b0;
      value         <= '0;
      value_valid   <= 1'b0;
      changed       <= 1'b0;
      sample_count  <= 16'd0;
      busy          <= 1'b0;
    end else begin
      enable_d    <= enable;
      value_valid <= 1'b0;
      changed     <= 1'b0;

      // Timer restarts a full period whenever polling is (re)enabled
      if (enable && !enable_d)
        timer <= TIMER_RELOAD;
      else if (enable)
        timer <= (timer == 16'd0) ? TIMER_RELOAD : timer - 16'd1;

      if (state != IDLE && (poll_now || timer_fire))
        pending <= 1'b1;

      case (state)
        IDLE: begin
          if (launch_req) begin
            address <= cfg_address;
            read    <= 1'b1;
            busy    <= 1'b1;
            pending <= 1'b0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (!waitrequest) begin
            read <= 1'b0;
            if (READ_LATENCY == 1) begin
              state <= CAPTURE;
            end else begin
              lat_cnt <= WAIT_LOAD;
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == 3'd0)
            state <= CAPTURE;
          else
            lat_cnt <= lat_cnt - 3'd1;
        end
        CAPTURE: begin
          value         <= readdata;
          value_valid   <= 1'b1;
          changed       <= first_capture || (readdata != value);
          first_capture <= 1'b0;
          sample_count  <= sample_count + 16'd1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_pio_poller.sv
// tb/tb_avalon_pio_poller.sv - scoreboard bench for avalon_pio_poller
module tb_avalon_pio_poller;
  localparam int DW  = 32;
  localparam int AW  = 2;
  localparam int LAT = 3;
  localparam int PER = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          poll_now = 1'b0;
  logic [AW-1:0] cfg_address = '0;
  logic [AW-1:0] address;
  logic          read;
  logic          waitrequest = 1'b0;
  logic [DW-1:0] readdata = '0;
  logic [DW-1:0] value;
  logic          value_valid;
  logic          changed;
  logic [15:0]   sample_count;
  logic          busy;

  avalon_pio_poller #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(LAT), .POLL_PERIOD(PER)) dut (
    .clk(clk), .reset(reset), .enable(enable), .poll_now(poll_now),
    .cfg_address(cfg_address), .address(address), .read(read),
    .waitrequest(waitrequest), .readdata(readdata), .value(value),
    .value_valid(value_valid), .changed(changed), .sample_count(sample_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] v;
    logic          ch;
    logic [15:0]   cnt;
  } exp_t;
  exp_t sb[$];

  task automatic expect_capture(input logic [DW-1:0] v, input logic ch, input logic [15:0] cnt);
    exp_t e;
    e.v = v; e.ch = ch; e.cnt = cnt;
    sb.push_back(e);
  endtask

  logic [DW-1:0] slave_data = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [AW-1:0] addr_prev = '0;
  logic          read_prev = 1'b0;
  int            acc_cyc = -100;
  int            read_run = 0;
  int            last_read_run = 0;
  int            launches = 0;
  int            rise_cyc[$];

  // Slave model and monitor: data is only correct in the cycle READ_LATENCY after acceptance
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      acc_cyc   = -100;
      read_prev = 1'b0;
      read_run  = 0;
    end else begin
      if (read) begin
        if (read_prev) begin
          check("addr_stable", address, addr_prev);
        end else begin
          launches++;
          rise_cyc.push_back(cyc);
          check("addr_launch", address, exp_addr);
        end
        read_run++;
        if (!waitrequest) begin
          acc_cyc       = cyc;
          last_read_run = read_run;
          read_run      = 0;
        end
      end
      addr_prev = address;
      read_prev = read;
      if (value_valid) begin
        check("vv_latency", cyc, acc_cyc + LAT + 1);
        check("vv_busy", busy, 1'b0);
        if (sb.size() == 0) begin
          check("vv_unexpected", value_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("value", value, e.v);
          check("changed", changed, e.ch);
          check("sample_count", sample_count, e.cnt);
        end
      end else if (changed) begin
        check("changed_alone", changed, 1'b0);
      end
    end
    readdata = (cyc == acc_cyc + LAT) ? slave_data : ~slave_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poll();
    poll_now = 1'b1;
    tick();
    poll_now = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      tick();
      if (!busy && !read && sb.size() == 0) break;
    end
    check({name, "_timeout"}, (k < 300), 1'b1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int l0;
    int en_cyc;
    int k;

    repeat (3) tick();
    check("rst_read", read, 1'b0);
    check("rst_address", address, 2'd0);
    check("rst_value", value, 32'd0);
    check("rst_value_valid", value_valid, 1'b0);
    check("rst_changed", changed, 1'b0);
    check("rst_sample_count", sample_count, 16'd0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // Single on-demand read; read is high for exactly one cycle
    cfg_address = 2'd2; exp_addr = 2'd2; slave_data = 32'h0000_00A5;
    expect_capture(32'h0000_00A5, 1'b1, 16'd1);
    poll();
    check("poll_read_high", read, 1'b1);
    check("poll_address", address, 2'd2);
    tick();
    check("poll_read_drop", read, 1'b0);
    check("poll_busy", busy, 1'b1);
    wait_done("poll1");

    expect_capture(32'h0000_00A5, 1'b0, 16'd2);
    poll();
    wait_done("poll2");

    slave_data = 32'h0000_005A;
    expect_capture(32'h0000_005A, 1'b1, 16'd3);
    poll();
    wait_done("poll3");

    // Stalled slave: three waitrequest cycles then acceptance
    cfg_address = 2'd1; exp_addr = 2'd1; slave_data = 32'h0000_1234;
    expect_capture(32'h0000_1234, 1'b1, 16'd4);
    waitrequest = 1'b1;
    poll();
    tick();
    tick();
    tick();
    waitrequest = 1'b0;
    wait_done("stall");
    check("stall_read_cycles", last_read_run, 4);

    // Two poll_now pulses while busy coalesce into one follow-up read
    slave_data = 32'h0000_0077;
    expect_capture(32'h0000_0077, 1'b1, 16'd5);
    expect_capture(32'h0000_0077, 1'b0, 16'd6);
    l0 = launches;
    poll();
    tick();
    poll_now = 1'b1;
    tick();
    poll_now = 1'b0;
    tick();
    poll_now = 1'b1;
    tick();
    poll_now = 1'b0;
    wait_done("coalesce");
    check("coalesce_reads", launches - l0, 2);

    // Periodic polling, then enable dropped mid-transaction
    cfg_address = 2'd0; exp_addr = 2'd0; slave_data = 32'h0000_0099;
    expect_capture(32'h0000_0099, 1'b1, 16'd7);
    expect_capture(32'h0000_0099, 1'b0, 16'd8);
    expect_capture(32'h0000_0099, 1'b0, 16'd9);
    r0 = rise_cyc.size();
    enable = 1'b1;
    en_cyc = cyc;
    for (k = 0; k < 100; k++) begin
      tick();
      if (rise_cyc.size() >= r0 + 3) break;
    end
    enable = 1'b0;
    check("timer_timeout", (k < 100), 1'b1);
    check("timer_busy_at_disable", busy, 1'b1);
    if (rise_cyc.size() >= r0 + 3) begin
      check("timer_first", rise_cyc[r0] - en_cyc, 11);
      check("timer_period1", rise_cyc[r0+1] - rise_cyc[r0], PER);
      check("timer_period2", rise_cyc[r0+2] - rise_cyc[r0+1], PER);
    end
    wait_done("timer");
    repeat (30) tick();
    check("timer_stopped", rise_cyc.size(), r0 + 3);

    // Reset during WAIT aborts the read without a capture
    cfg_address = 2'd2; exp_addr = 2'd2; slave_data = 32'h0000_0055;
    poll();
    tick();
    reset = 1'b1;
    tick();
    check("abort_read", read, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_value", value, 32'd0);
    check("abort_value_valid", value_valid, 1'b0);
    check("abort_changed", changed, 1'b0);
    check("abort_address", address, 2'd0);
    check("abort_sample_count", sample_count, 16'd0);
    reset = 1'b0;
    repeat (10) tick();
    check("abort_no_capture", sample_count, 16'd0);

    // Counter wrap; first capture after reset flags changed even with equal data
    @(negedge clk);
    force dut.sample_count = 16'hFFFF;
    @(negedge clk);
    release dut.sample_count;
    tick();
    cfg_address = 2'd3; exp_addr = 2'd3; slave_data = 32'h0000_0000;
    expect_capture(32'h0000_0000, 1'b1, 16'd0);
    poll();
    wait_done("wrap");
    check("wrap_count", sample_count, 16'd0);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
